// File: rtl/secuenciador_melodia_if.sv
// Control and key-output bundle between the melody sequencer and its user.
// The master side drives start/stop/loop; the slave side (sequencer) drives the rest.
interface secuenciador_melodia_if;
   logic       start;
   logic       stop;
   logic       loop;
   logic [6:0] teclas;
   logic       busy;
   logic [3:0] note_idx;
   logic       done;

   modport master (
      output start, stop, loop,
      input  teclas, busy, note_idx, done
   );

   modport slave (
      input  start, stop, loop,
      output teclas, busy, note_idx, done
   );
endinterface

// File: rtl/secuenciador_melodia.sv
// Melody source for the music-box tone generator: walks a constant note table,
// holding each key mask for dur ms followed by an optional silent gap.
module secuenciador_melodia #(
   parameter int TICK_DIV = 50000,
   parameter int GAP_MS   = 10
) (
   input logic                    clk,
   input logic                    reset,
   secuenciador_melodia_if.slave  bus
);

   localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [9:0]     GAP_LAST   = 10'(GAP_MS - 1);

   typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

   function automatic logic [6:0] entry_keys(input logic [3:0] i);
      case (i)
         4'd0:    entry_keys = 7'b0000001;
         4'd1:    entry_keys = 7'b0000010;
         4'd3:    entry_keys = 7'b0000100;
         4'd4:    entry_keys = 7'b0001000;
         4'd5:    entry_keys = 7'b0010000;
         4'd6:    entry_keys = 7'b0100000;
         4'd7:    entry_keys = 7'b1000000;
         default: entry_keys = 7'b0000000;
      endcase
   endfunction

   // A zero duration marks the end of the melody.
   function automatic logic [9:0] entry_dur(input logic [3:0] i);
      case (i)
         4'd0, 4'd1, 4'd4, 4'd5, 4'd6: entry_dur = 10'd200;
         4'd2:                         entry_dur = 10'd100;
         4'd3, 4'd7:                   entry_dur = 10'd400;
         default:                      entry_dur = 10'd0;
      endcase
   endfunction

   state_t        state;
   logic          start_q;
   logic [PW-1:0] presc;
   logic [9:0]    ms_cnt;
   logic [6:0]    teclas_r;
   logic          busy_r;
   logic [3:0]    note_idx_r;
   logic          done_r;

   logic [3:0]    next_idx;
   logic [9:0]    next_dur;
   logic [9:0]    first_dur;
   logic [9:0]    ms_last;
   logic          start_edge;
   logic          tick;

   assign next_idx   = note_idx_r + 4'd1;
   assign next_dur   = entry_dur(next_idx);
   assign first_dur  = entry_dur(4'd0);
   assign ms_last    = (state == GAP) ? GAP_LAST : entry_dur(note_idx_r) - 10'd1;
   assign start_edge = bus.start & ~start_q;
   assign tick       = (presc == PRESC_LAST);

   assign bus.teclas   = teclas_r;
   assign bus.busy     = busy_r;
   assign bus.note_idx = note_idx_r;
   assign bus.done     = done_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         start_q    <= 1'b0;
         presc      <= '0;
         ms_cnt     <= '0;
         teclas_r   <= '0;
         busy_r     <= 1'b0;
         note_idx_r <= '0;
         done_r     <= 1'b0;
      end else begin
         start_q <= bus.start;
         done_r  <= 1'b0;
         if (bus.stop) begin
            state      <= IDLE;
            presc      <= '0;
            ms_cnt     <= '0;
            teclas_r   <= '0;
            busy_r     <= 1'b0;
            note_idx_r <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_edge) begin
                     presc      <= '0;
                     ms_cnt     <= '0;
                     note_idx_r <= '0;
                     if (first_dur != 10'd0) begin
                        state    <= PLAY;
                        teclas_r <= entry_keys(4'd0);
                        busy_r   <= 1'b1;
                     end else begin
                        state    <= DONE;
                        teclas_r <= '0;
                        done_r   <= 1'b1;
                     end
                  end
               end
               PLAY, GAP: begin
                  if (!tick) begin
                     presc <= presc + 1'b1;
                  end else begin
                     presc <= '0;
                     if (ms_cnt != ms_last) begin
                        ms_cnt <= ms_cnt + 10'd1;
                     end else begin
                        ms_cnt <= '0;
                        // End of a note or gap: either insert the gap or fetch the next entry.
                        if (state == PLAY && GAP_MS != 0) begin
                           state    <= GAP;
                           teclas_r <= '0;
                        end else if (next_dur != 10'd0) begin
                           state      <= PLAY;
                           teclas_r   <= entry_keys(next_idx);
                           note_idx_r <= next_idx;
                        end else if (bus.loop && first_dur != 10'd0) begin
                           state      <= PLAY;
                           teclas_r   <= entry_keys(4'd0);
                           note_idx_r <= '0;
                        end else begin
                           state      <= DONE;
                           teclas_r   <= '0;
                           busy_r     <= 1'b0;
                           done_r     <= 1'b1;
                           note_idx_r <= next_idx;
                        end
                     end
                  end
               end
               DONE: begin
                  state      <= IDLE;
                  note_idx_r <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_secuenciador_melodia.sv
// Self-checking bench for secuenciador_melodia: randomized start/stop/loop activity
// compared frame by frame against a table-driven model of the melody timeline.
module tb_secuenciador_melodia;

   localparam int TICK = 4;
   localparam int GAPM = 1;

   typedef struct packed {
      logic [6:0] teclas;
      logic       busy;
      logic [3:0] idx;
      logic       done;
   } frame_t;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   logic [6:0] keys_tbl [16] = '{7'b0000001, 7'b0000010, 7'b0000000, 7'b0000100,
                                 7'b0001000, 7'b0010000, 7'b0100000, 7'b1000000,
                                 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0};
   int         dur_tbl  [16] = '{200, 200, 100, 400, 200, 200, 200, 400,
                                 0, 0, 0, 0, 0, 0, 0, 0};

   frame_t exp_q [$];

   secuenciador_melodia_if bus ();

   secuenciador_melodia #(.TICK_DIV(TICK), .GAP_MS(GAPM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycles from the first PLAY cycle of entry 0 to the first PLAY cycle of entry n.
   function automatic int entry_offset(input int n);
      int sum;
      sum = 0;
      for (int e = 0; e < n; e++) sum += (dur_tbl[e] + GAPM) * TICK;
      return sum;
   endfunction

   function automatic int pass_len();
      int e;
      e = 0;
      while (e < 16 && dur_tbl[e] != 0) e++;
      return entry_offset(e);
   endfunction

   // Expected per-cycle outputs after a start edge; 'loops' terminators wrap before the final one ends.
   task automatic build_melody(input int loops);
      int     e;
      int     passes;
      frame_t f;
      exp_q.delete();
      e = 0;
      passes = 0;
      while (1) begin
         if (dur_tbl[e] == 0) begin
            if (passes < loops) begin
               passes++;
               e = 0;
               continue;
            end
            f = '{teclas: 7'b0, busy: 1'b0, idx: 4'(e), done: 1'b1};
            exp_q.push_back(f);
            f = '{teclas: 7'b0, busy: 1'b0, idx: 4'd0, done: 1'b0};
            exp_q.push_back(f);
            break;
         end
         f = '{teclas: keys_tbl[e], busy: 1'b1, idx: 4'(e), done: 1'b0};
         repeat (dur_tbl[e] * TICK) exp_q.push_back(f);
         f = '{teclas: 7'b0, busy: 1'b1, idx: 4'(e), done: 1'b0};
         repeat (GAPM * TICK) exp_q.push_back(f);
         e = (e + 1) % 16;
      end
   endtask

   task automatic kick();
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic run_frames(input string name, input int n, input bit jitter);
      int          bad;
      int          first_bad;
      logic [12:0] got;
      logic [12:0] got_first;
      logic [12:0] exp_first;
      frame_t      f;
      bad = 0;
      first_bad = -1;
      got_first = '0;
      exp_first = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            bad++;
            break;
         end
         f = exp_q.pop_front();
         got = {bus.teclas, bus.busy, bus.note_idx, bus.done};
         if (got !== f) begin
            if (bad == 0) begin
               first_bad = i;
               got_first = got;
               exp_first = f;
            end
            bad++;
         end
         if (jitter && f.busy) bus.start = 1'($urandom_range(0, 1));
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("[TB] FAIL %s: %0d bad frames, first at %0d got {teclas,busy,idx,done}=%h required %h",
                  name, bad, first_bad, got_first, exp_first);
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (bus.teclas !== 7'b0) begin
         errors++;
         $display("[TB] FAIL %s teclas: got %b required 0000000", name, bus.teclas);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s busy: got %b required 0", name, bus.busy);
      end
      checks++;
      if (bus.note_idx !== 4'd0) begin
         errors++;
         $display("[TB] FAIL %s note_idx: got %0d required 0", name, bus.note_idx);
      end
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s done: got %b required 0", name, bus.done);
      end
   endtask

   task automatic stop_and_check(input string name);
      bus.stop = 1'b1;
      @(negedge clk);
      check_idle(name);
      bus.stop  = 1'b0;
      bus.start = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_idle("reset_state");
      reset = 1'b0;
      @(negedge clk);
      check_idle("idle_after_reset");
   endtask

   task automatic test_play_once();
      bus.loop = 1'b0;
      build_melody(0);
      kick();
      run_frames("melody_once", exp_q.size(), 1'b1);
      bus.start = 1'b0;
   endtask

   task automatic test_loop();
      bus.loop = 1'b1;
      build_melody(1);
      kick();
      run_frames("melody_loop", pass_len() + 200, 1'b1);
      stop_and_check("loop_stop");
   endtask

   task automatic test_loop_change();
      int n1;
      int n2;
      bus.loop = 1'b0;
      build_melody(1);
      n1 = $urandom_range(1, pass_len() - 10);
      n2 = $urandom_range(1, pass_len() - 10);
      kick();
      run_frames("loopchg_pass1a", n1, 1'b1);
      bus.loop = 1'b1;
      run_frames("loopchg_pass1b", pass_len() - n1, 1'b1);
      run_frames("loopchg_pass2a", n2, 1'b1);
      bus.loop = 1'b0;
      run_frames("loopchg_pass2b", exp_q.size(), 1'b1);
      bus.start = 1'b0;
   endtask

   task automatic test_stop();
      int off;
      bus.loop = 1'b0;
      for (int r = 0; r < 5; r++) begin
         off = (r == 0) ? entry_offset(3) + 300 : $urandom_range(1, 5000);
         build_melody(0);
         kick();
         run_frames("stop_prefix", off, 1'b1);
         stop_and_check("stop_result");
         build_melody(0);
         kick();
         run_frames("stop_restart", 40, 1'b0);
         stop_and_check("stop_cleanup");
      end
   endtask

   task automatic test_start_stop_same();
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      @(negedge clk);
      check_idle("start_stop_same");
      bus.stop = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL start_held_no_edge busy: got %b required 0", bus.busy);
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset_mid_note();
      bus.loop = 1'b0;
      build_melody(0);
      kick();
      run_frames("pre_reset", $urandom_range(10, 5000), 1'b1);
      reset     = 1'b1;
      bus.start = 1'b0;
      @(negedge clk);
      check_idle("reset_mid_note");
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check_idle("after_mid_reset");
   endtask

   task automatic test_reset_start_held();
      reset     = 1'b1;
      bus.start = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      build_melody(0);
      run_frames("start_through_reset", 60, 1'b0);
      stop_and_check("start_held_stop");
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.loop  = 1'b0;
      test_reset();
      test_play_once();
      test_loop();
      test_loop_change();
      test_stop();
      test_start_stop_same();
      test_reset_mid_note();
      test_reset_start_held();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/secuenciador_melodia.md
SECUENCIADOR_MELODIA -- requirements
Module: secuenciador_melodia

Interface
REQ-001 The block SHALL be the upstream melody source for the music-box tone generator, driving its 7-bit key input from an internal note table.
REQ-002 Parameter TICK_DIV, default 50000, SHALL set the number of clk cycles per 1 ms time unit (50 MHz clock).
REQ-003 Parameter GAP_MS, default 10, SHALL set the silence in ms inserted after every note; 0 means no gap.
REQ-004 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 start  input  1  SHALL request playback from entry 0 on its rising edge.
REQ-007 stop  input  1  SHALL abort playback, level-sensitive.
REQ-008 loop  input  1  SHALL cause playback to restart at entry 0 after the terminator when high.
REQ-009 teclas  output  7  SHALL be the key mask presented to the tone generator; one-hot or zero.
REQ-010 busy  output  1  SHALL be high in states PLAY and GAP.
REQ-011 note_idx  output  4  SHALL be the index of the table entry currently playing.
REQ-012 done  output  1  SHALL be a one-cycle pulse when a non-looped melody completes.

Function
REQ-013 The table SHALL hold 16 constant entries {keys[6:0], dur[9:0] in ms}; dur=0 marks the terminator.
REQ-014 Default contents SHALL be: 0:{0000001,200} 1:{0000010,200} 2:{0000000,100} 3:{0000100,400} 4:{0001000,200} 5:{0010000,200} 6:{0100000,200} 7:{1000000,400} 8:{0000000,0}; entries 9-15 SHALL be terminators.
REQ-015 States SHALL be IDLE, PLAY, GAP and DONE.
REQ-016 The start rising edge SHALL be detected against a registered copy of start; the registered copy SHALL be reset to 0.
REQ-017 In IDLE with a start edge sampled at edge k, the block SHALL enter PLAY at k with note_idx=0, so teclas=keys[0] from cycle k+1.
REQ-018 PLAY SHALL hold teclas=keys[note_idx] for exactly dur*TICK_DIV cycles, counted by a prescaler of TICK_DIV cycles plus a 10-bit ms counter, both cleared on every PLAY or GAP entry.
REQ-019 After PLAY the block SHALL enter GAP with teclas=0 for GAP_MS*TICK_DIV cycles; if GAP_MS=0 it SHALL go directly to the next entry.
REQ-020 After GAP the block SHALL increment note_idx (4-bit, wraps 15->0) and read that entry.
REQ-021 Rest entries (keys=0, dur>0) SHALL be timed exactly like notes.
REQ-022 Reading a terminator SHALL, in the same cycle, restart PLAY at entry 0 if loop=1; otherwise it SHALL enter DONE.
REQ-023 DONE SHALL last one cycle with done=1 and teclas=0, then return to IDLE.
REQ-024 A terminator at entry 0 SHALL produce DONE immediately, with no PLAY cycles.
REQ-025 stop=1 sampled in any state SHALL force IDLE on that edge with teclas=0 and note_idx=0; stop SHALL win over a simultaneous start.
REQ-026 A start edge while busy SHALL be ignored.
REQ-027 A loop change SHALL take effect only at the next terminator.

Reset
REQ-028 reset SHALL have priority over all other inputs.
REQ-029 The reset state SHALL be IDLE with teclas=0, busy=0, note_idx=0, done=0, prescaler=0, ms counter=0 and registered start=0.
REQ-030 reset asserted mid-note SHALL silence teclas on the next cycle.
REQ-031 start held high through reset release SHALL trigger playback once, on the first cycle after release.

Verification (TICK_DIV=4, GAP_MS=1)
REQ-032 Pulse start for one cycle -> teclas=0000001 for 800 cycles, then 0 for 4 cycles, then 0000010 for 800 cycles; busy=1 throughout.
REQ-033 Run to the end with loop=0 -> entry 2 is silent for 400 cycles, entry 7 plays 1000000 for 1600 cycles, then done is high for exactly 1 cycle and busy=0.
REQ-034 Run with loop=1 -> no done pulse, and teclas=0000001 appears 1 cycle after the terminator is read.
REQ-035 Assert stop at cycle 300 of entry 3 -> next cycle teclas=0, busy=0, note_idx=0; a later start restarts at entry 0.
REQ-036 Assert start and stop in the same cycle from IDLE -> block stays in IDLE with teclas=0.
REQ-037 Assert reset mid-note -> all outputs reach their reset values one cycle later.
